// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and default operand width for the serial adder
package serial_add_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int NBYTES_DEF = 4;
endpackage

// File: rtl/adder_8.sv
// adder_8: one byte of the serial datapath with carry and signed-overflow outputs
module adder_8 (
   output logic [7:0] s,
   output logic       co,
   output logic       of,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       ci
);
   // byte sum; overflow when equal-signed operands give a result of the other sign
   always_comb begin
      {co, s} = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      of = (a[7] == b[7]) && (s[7] != a[7]);
   end
endmodule

// File: rtl/serial_add_seq.sv
// serial_add_seq: byte-serial add/subtract with valid/ready handshakes on both sides
module serial_add_seq
   import serial_add_pkg::*;
#(
   parameter int NBYTES = NBYTES_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [8*NBYTES-1:0] a,
   input  logic [8*NBYTES-1:0] b,
   input  logic                ci,
   input  logic                op_sub,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [8*NBYTES-1:0] s,
   output logic                co,
   output logic                of
);
   localparam int W  = 8 * NBYTES;
   localparam int IW = $clog2(NBYTES);

   state_t          state;
   logic [IW-1:0]   idx;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic            carry;
   logic [7:0]      byte_s;
   logic            byte_co;
   logic            byte_of;

   // Operands shift right one byte per RUN cycle so the adder always sees the current byte at [7:0].
   adder_8 u_adder (
      .s  (byte_s),
      .co (byte_co),
      .of (byte_of),
      .a  (a_q[7:0]),
      .b  (b_q[7:0]),
      .ci (carry)
   );

   // Control FSM and datapath registers; subtract is folded in at capture as A + ~B + 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         carry     <= 1'b0;
         s         <= '0;
         co        <= 1'b0;
         of        <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_q      <= a;
               b_q      <= op_sub ? ~b : b;
               carry    <= op_sub | ci;
               idx      <= '0;
               in_ready <= 1'b0;
               state    <= RUN;
            end
            RUN: begin
               s     <= {byte_s, s[W-1:8]};
               a_q   <= a_q >> 8;
               b_q   <= b_q >> 8;
               carry <= byte_co;
               idx   <= idx + 1'b1;
               if (idx == IW'(NBYTES - 1)) begin
                  co        <= byte_co;
                  of        <= byte_of;
                  idx       <= '0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: directed table, handshake corner cases and random checks against an arithmetic model
module tb_serial_add_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        ci = 1'b0;
   logic        op_sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] s;
   logic        co;
   logic        of;

   int n_cmp = 0;
   int n_bad = 0;

   serial_add_seq #(.NBYTES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ci(ci), .op_sub(op_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .co(co), .of(of)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain signed/unsigned arithmetic on whole words.
   task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mci, input logic msub,
                        output logic [31:0] ms, output logic mco, output logic mof);
      longint sa, sb, sr;
      logic [32:0] u;
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      if (msub) begin
         ms  = ma - mb;
         mco = (ma >= mb);
         sr  = sa - sb;
      end else begin
         u   = {1'b0, ma} + {1'b0, mb} + {32'd0, mci};
         ms  = u[31:0];
         mco = u[32];
         sr  = sa + sb + longint'(mci);
      end
      mof = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
   endtask

   // One full transaction: accept, scramble inputs, time the result, hold in DONE, release.
   task automatic do_op(input logic [31:0] ta, input logic [31:0] tb2, input logic tci, input logic tsub,
                        input int hold, input logic [31:0] es, input logic eco, input logic eof);
      int lat;
      logic [31:0] rs;
      logic rco, rof;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1'b1);
      a = ta; b = tb2; ci = tci; op_sub = tsub; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; ci = 1'($urandom); op_sub = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 64'(lat), 64'd4);
      chk("s", s, es);
      chk("co", co, eco);
      chk("of", of, eof);
      chk("busy_in_ready", in_ready, 1'b0);
      rs = s; rco = co; rof = of;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; a = $urandom; b = $urandom;
         @(posedge clk); #1;
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_in_ready", in_ready, 1'b0);
         chk("hold_s", s, rs);
         chk("hold_flags", {co, of}, {rco, rof});
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_valid", out_valid, 1'b0);
      chk("release_in_ready", in_ready, 1'b1);
   endtask

   typedef struct {
      logic [31:0] a, b;
      logic        ci, sub;
      logic [31:0] s;
      logic        co, of;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [31:0] ra, rb, es;
      logic rci, rsub, eco, eof;
      vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
      vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
      vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
      vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
      vecs[4] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
      vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_s", s, 32'h0);
      chk("rst_flags", {co, of}, 2'b00);
      rst = 1'b0;

      foreach (vecs[i])
         do_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, 0, vecs[i].s, vecs[i].co, vecs[i].of);

      // Output stall with new operands offered while DONE.
      do_op(32'h12345678, 32'h0FEDCBA9, 1'b1, 1'b0, 3, 32'h22222222, 1'b0, 1'b0);

      // Reset during the second RUN cycle abandons the operation.
      @(negedge clk);
      a = 32'hDEADBEEF; b = 32'h11111111; ci = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_in_ready", in_ready, 1'b1);
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_s", s, 32'h0);
      repeat (5) @(posedge clk);
      #1;
      chk("mid_rst_no_result", out_valid, 1'b0);
      do_op(32'h00010000, 32'h0000FFFF, 1'b1, 1'b0, 1, 32'h00020000, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         ra = $urandom; rb = $urandom; rci = 1'($urandom); rsub = 1'($urandom);
         if (i % 5 == 0) rb = ~ra;
         model(ra, rb, rci, rsub, es, eco, eof);
         do_op(ra, rb, rci, rsub, int'($urandom_range(0, 2)), es, eco, eof);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
